// File: rtl/bus_arbiter_if.sv
// Signal bundle between bus_arbiter, its two requesters, the shared memory bus and pipeline control.
// bus_err_o exists only when ARB_TIMEOUT_EN is defined.
interface bus_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ack_o;

    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_ack_o;

    logic        bus_ce_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;

    logic        flush_i;
    logic        stallreq_if_o;
    logic        stallreq_mem_o;
`ifdef ARB_TIMEOUT_EN
    logic        bus_err_o;
`endif

    // Arbiter side
    modport slave (
`ifdef ARB_TIMEOUT_EN
        output bus_err_o,
`endif
        input  if_req_i, if_addr_i,
        output if_data_o, if_ack_o,
        input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
        output mem_data_o, mem_ack_o,
        output bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o,
        input  bus_data_i, bus_ack_i,
        input  flush_i,
        output stallreq_if_o, stallreq_mem_o
    );

    // Requester / memory / pipeline side
    modport master (
`ifdef ARB_TIMEOUT_EN
        input  bus_err_o,
`endif
        output if_req_i, if_addr_i,
        input  if_data_o, if_ack_o,
        output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
        input  mem_data_o, mem_ack_o,
        input  bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o,
        output bus_data_i, bus_ack_i,
        output flush_i,
        input  stallreq_if_o, stallreq_mem_o
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter onto a single-port memory bus, MEM has priority.
// Define ARB_TIMEOUT_EN to add a 255-cycle bus timeout with bus_err_o.
module bus_arbiter (
    input  logic         clk,
    input  logic         rst,
    bus_arbiter_if.slave arb_if
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_gnt_mem;
    logic        r_flushed;
    logic        r_ce;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_if_data;
    logic [31:0] r_mem_data;
    logic        r_if_ack;
    logic        r_mem_ack;
    logic        w_busy;
    logic        w_timeout;

    assign w_busy = (r_state == BUSY_IF) || (r_state == BUSY_MEM);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_timed_out;
    logic       r_bus_err;

    // Counter value 254 on an ack-less cycle marks the 255th BUSY cycle
    assign w_timeout = w_busy && !arb_if.bus_ack_i && (r_cnt == 8'd254);
    assign arb_if.bus_err_o = r_bus_err;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (arb_if.mem_req_i)     w_next = BUSY_MEM;
                else if (arb_if.if_req_i) w_next = BUSY_IF;
            end
            BUSY_IF, BUSY_MEM: begin
                if (arb_if.bus_ack_i || w_timeout) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt_mem   <= 1'b0;
            r_flushed   <= 1'b0;
            r_ce        <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_data   <= '0;
            r_mem_data  <= '0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
            r_bus_err   <= 1'b0;
`endif
        end else begin
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_bus_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_next == BUSY_MEM) begin
                        r_gnt_mem <= 1'b1;
                        r_ce      <= 1'b1;
                        r_we      <= arb_if.mem_we_i;
                        r_sel     <= arb_if.mem_sel_i;
                        r_addr    <= arb_if.mem_addr_i;
                        r_wdata   <= arb_if.mem_data_i;
                        r_flushed <= 1'b0;
                    end else if (w_next == BUSY_IF) begin
                        r_gnt_mem <= 1'b0;
                        r_ce      <= 1'b1;
                        r_we      <= 1'b0;
                        r_sel     <= 4'hF;
                        r_addr    <= arb_if.if_addr_i;
                        r_wdata   <= '0;
                        // A flush coinciding with the IF grant already cancels its ack
                        r_flushed <= arb_if.flush_i;
                    end
`ifdef ARB_TIMEOUT_EN
                    r_cnt       <= '0;
                    r_timed_out <= 1'b0;
`endif
                end
                BUSY_IF, BUSY_MEM: begin
                    if ((r_state == BUSY_IF) && arb_if.flush_i) r_flushed <= 1'b1;
                    if (arb_if.bus_ack_i) begin
                        r_ce <= 1'b0;
                        if (!r_we) begin
                            if (r_gnt_mem) r_mem_data <= arb_if.bus_data_i;
                            else           r_if_data  <= arb_if.bus_data_i;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_ce        <= 1'b0;
                        r_timed_out <= 1'b1;
                        if (r_gnt_mem) r_mem_data <= '0;
                        else           r_if_data  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    if (r_gnt_mem) r_mem_ack <= 1'b1;
                    else           r_if_ack  <= !(r_flushed || arb_if.flush_i);
`ifdef ARB_TIMEOUT_EN
                    r_bus_err <= r_timed_out;
`endif
                end
                default: ;
            endcase
        end
    end

    assign arb_if.bus_ce_o       = r_ce;
    assign arb_if.bus_we_o       = r_we;
    assign arb_if.bus_sel_o      = r_sel;
    assign arb_if.bus_addr_o     = r_addr;
    assign arb_if.bus_data_o     = r_wdata;
    assign arb_if.if_data_o      = r_if_data;
    assign arb_if.mem_data_o     = r_mem_data;
    assign arb_if.if_ack_o       = r_if_ack;
    assign arb_if.mem_ack_o      = r_mem_ack;
    assign arb_if.stallreq_if_o  = arb_if.if_req_i  && !r_if_ack;
    assign arb_if.stallreq_mem_o = arb_if.mem_req_i && !r_mem_ack;
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, directed corner sequences and randomized
// transactions scored against a transaction-level model. Define ARB_TIMEOUT_EN to cover the timeout.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_if ifc ();
    bus_arbiter dut (.clk(clk), .rst(rst), .arb_if(ifc));

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] exp_if_data  = '0;
    logic [31:0] exp_mem_data = '0;

    typedef struct {
        bit          is_mem;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned wt;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_bdata;
        logic [31:0] e_data;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drop(input bit is_mem);
        if (is_mem) ifc.mem_req_i = 1'b0;
        else        ifc.if_req_i  = 1'b0;
    endtask

    task automatic scramble(input bit is_mem);
        if (is_mem) begin
            ifc.mem_we_i   = 1'($urandom());
            ifc.mem_sel_i  = 4'($urandom());
            ifc.mem_addr_i = $urandom();
            ifc.mem_data_i = $urandom();
        end else begin
            ifc.if_addr_i  = $urandom();
        end
    endtask

    // Called right after requests are driven with the arbiter idle; returns on the ack-cycle negedge.
    task automatic serve(input bit is_mem, input logic [31:0] e_addr, input logic e_we,
                         input logic [3:0] e_sel, input logic [31:0] e_bdata, input logic [31:0] rdata,
                         input int unsigned wt, input int unsigned flush_at, input int unsigned drop_at,
                         input bit hold2, input bit keep_req, input bit e_ack, input logic [31:0] e_data);
        int unsigned waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!ifc.bus_ce_o && waited < 8);
        check("grant_latency", waited, 1);
        if (!ifc.bus_ce_o) begin
            drop(is_mem);
            return;
        end
        for (int unsigned c = 1; c <= wt + 1; c++) begin
            if (c > 1) @(negedge clk);
            check("bus_hold", {ifc.bus_ce_o, ifc.bus_we_o, ifc.bus_sel_o, ifc.bus_addr_o, ifc.bus_data_o},
                  {1'b1, e_we, e_sel, e_addr, e_bdata});
            check("stall_ack_busy", {ifc.stallreq_if_o, ifc.stallreq_mem_o, ifc.if_ack_o, ifc.mem_ack_o},
                  {ifc.if_req_i, ifc.mem_req_i, 2'b00});
            ifc.flush_i = (c == flush_at);
            if (c == drop_at) drop(is_mem);
            scramble(is_mem);
            ifc.bus_ack_i  = (c == wt + 1);
            ifc.bus_data_i = (c == wt + 1) ? rdata : $urandom();
        end
        @(negedge clk);
        check("done_quiet", {ifc.bus_ce_o, ifc.if_ack_o, ifc.mem_ack_o}, 3'b000);
        ifc.flush_i    = (flush_at == wt + 2);
        ifc.bus_ack_i  = hold2;
        ifc.bus_data_i = $urandom();
        @(negedge clk);
        check("ack", {ifc.if_ack_o, ifc.mem_ack_o}, {!is_mem && e_ack, is_mem && e_ack});
        check("rdata", is_mem ? ifc.mem_data_o : ifc.if_data_o, e_data);
        check("stallreq_ack", is_mem ? ifc.stallreq_mem_o : ifc.stallreq_if_o,
              (is_mem ? ifc.mem_req_i : ifc.if_req_i) && !e_ack);
        ifc.flush_i   = 1'b0;
        ifc.bus_ack_i = 1'b0;
        if (!keep_req) drop(is_mem);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        int unsigned pick, m_wt, m_drop, m_flush, i_wt, i_drop, i_flush, fl, cnt;
        logic        m_we;
        logic [3:0]  m_sel;
        logic [31:0] m_addr, m_wdata, m_rdata, i_addr, i_rdata, e_d;

        //             mem we  sel    addr          wdata         rdata         wt e_we e_sel  e_bdata       e_data
        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,        32'h3421_0001, 0, 1'b0, 4'hF, 32'h0,        32'h3421_0001};
        vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h1234_5678, 32'hCAFE_F00D, 0, 1'b0, 4'hF, 32'h1234_5678, 32'hCAFE_F00D};
        vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_0200, 32'hDEAD_BEEF, 32'h5555_AAAA, 2, 1'b1, 4'h3, 32'hDEAD_BEEF, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,        32'h0,         3, 1'b0, 4'hF, 32'h0,        32'h0};
        vecs[4] = '{1'b1, 1'b0, 4'h4, 32'h8000_0000, 32'h0,        32'hFFFF_FFFF, 1, 1'b0, 4'h4, 32'h0,        32'hFFFF_FFFF};
        vecs[5] = '{1'b0, 1'b0, 4'h0, 32'h0000_0004, 32'h0,        32'hA5A5_5A5A, 1, 1'b0, 4'hF, 32'h0,        32'hA5A5_5A5A};

        ifc.if_req_i = 1'b0;  ifc.if_addr_i = '0;
        ifc.mem_req_i = 1'b0; ifc.mem_we_i = 1'b0; ifc.mem_sel_i = '0; ifc.mem_addr_i = '0; ifc.mem_data_i = '0;
        ifc.bus_data_i = '0;  ifc.bus_ack_i = 1'b0; ifc.flush_i = 1'b0;

        #1;
        check("reset_bus", {ifc.bus_ce_o, ifc.bus_we_o, ifc.bus_sel_o, ifc.bus_addr_o, ifc.bus_data_o}, '0);
        check("reset_port", {ifc.if_ack_o, ifc.mem_ack_o, ifc.if_data_o, ifc.mem_data_o}, '0);
`ifdef ARB_TIMEOUT_EN
        check("reset_err", ifc.bus_err_o, 1'b0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int unsigned v = 0; v < 6; v++) begin
            scramble(!vecs[v].is_mem);
            if (vecs[v].is_mem) begin
                ifc.mem_req_i  = 1'b1;
                ifc.mem_we_i   = vecs[v].we;
                ifc.mem_sel_i  = vecs[v].sel;
                ifc.mem_addr_i = vecs[v].addr;
                ifc.mem_data_i = vecs[v].wdata;
            end else begin
                ifc.if_req_i   = 1'b1;
                ifc.if_addr_i  = vecs[v].addr;
            end
            serve(vecs[v].is_mem, vecs[v].addr, vecs[v].e_we, vecs[v].e_sel, vecs[v].e_bdata,
                  vecs[v].rdata, vecs[v].wt, 0, 0, 1'b0, 1'b0, 1'b1, vecs[v].e_data);
            if (vecs[v].is_mem) exp_mem_data = vecs[v].e_data;
            else                exp_if_data  = vecs[v].e_data;
        end

        // bus_ack_i while idle is ignored
        ifc.bus_ack_i = 1'b1;
        ifc.bus_data_i = 32'h7777_7777;
        for (int unsigned k = 0; k < 3; k++) begin
            @(negedge clk);
            ifc.bus_ack_i = 1'b0;
            check("idle_ack_ignored", {ifc.bus_ce_o, ifc.if_ack_o, ifc.mem_ack_o, ifc.if_data_o, ifc.mem_data_o},
                  {3'b000, exp_if_data, exp_mem_data});
        end

        // Simultaneous requests: MEM store first, then IF
        ifc.if_req_i = 1'b1;  ifc.if_addr_i = 32'h0000_0300;
        ifc.mem_req_i = 1'b1; ifc.mem_we_i = 1'b1; ifc.mem_sel_i = 4'b0011;
        ifc.mem_addr_i = 32'h0000_0200; ifc.mem_data_i = 32'hDEAD_BEEF;
        serve(1'b1, 32'h200, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h9999_0000, 1, 0, 0, 1'b0, 1'b0, 1'b1, exp_mem_data);
        serve(1'b0, 32'h300, 1'b0, 4'hF, 32'h0, 32'h1111_2222, 0, 0, 0, 1'b0, 1'b0, 1'b1, 32'h1111_2222);
        exp_if_data = 32'h1111_2222;

        // Flush on 2nd BUSY cycle of a 5-wait IF read: six ce cycles, no ack, back to idle
        ifc.if_req_i = 1'b1; ifc.if_addr_i = 32'h0000_0400;
        serve(1'b0, 32'h400, 1'b0, 4'hF, 32'h0, 32'h0BAD_0BAD, 5, 2, 2, 1'b0, 1'b0, 1'b0, 32'h0BAD_0BAD);
        exp_if_data = 32'h0BAD_0BAD;
        for (int unsigned k = 0; k < 2; k++) begin
            @(negedge clk);
            check("flush_idle", {ifc.bus_ce_o, ifc.if_ack_o}, 2'b00);
        end

        // Flush together with the IF grant, then flush during DONE
        ifc.if_req_i = 1'b1; ifc.if_addr_i = 32'h0000_0410; ifc.flush_i = 1'b1;
        serve(1'b0, 32'h410, 1'b0, 4'hF, 32'h0, 32'h0000_0410, 1, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0410);
        ifc.if_req_i = 1'b1; ifc.if_addr_i = 32'h0000_0420;
        serve(1'b0, 32'h420, 1'b0, 4'hF, 32'h0, 32'h0000_0420, 0, 2, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0420);
        exp_if_data = 32'h0000_0420;

        // MEM load with req dropped mid-transaction still acks; flush has no effect on MEM
        ifc.mem_req_i = 1'b1; ifc.mem_we_i = 1'b0; ifc.mem_sel_i = 4'hC;
        ifc.mem_addr_i = 32'h0000_0480; ifc.mem_data_i = 32'h0;
        serve(1'b1, 32'h480, 1'b0, 4'hC, 32'h0, 32'h4848_4848, 2, 2, 1, 1'b1, 1'b0, 1'b1, 32'h4848_4848);
        exp_mem_data = 32'h4848_4848;

        // Back-to-back IF with req held: grant every third cycle, address tracks input
        ifc.if_req_i = 1'b1; ifc.if_addr_i = 32'h0000_1000;
        for (int unsigned k = 0; k < 4; k++) begin
            serve(1'b0, 32'h1000 + 32'(k * 4), 1'b0, 4'hF, 32'h0, 32'hB000_0000 + 32'(k), 0, 0, 0,
                  1'b0, (k < 3), 1'b1, 32'hB000_0000 + 32'(k));
            ifc.if_addr_i = 32'h1000 + 32'((k + 1) * 4);
        end
        exp_if_data = 32'hB000_0003;

        // Asynchronous reset mid BUSY_MEM, then first arbitration right after release
        ifc.mem_req_i = 1'b1; ifc.mem_we_i = 1'b0; ifc.mem_sel_i = 4'hF;
        ifc.mem_addr_i = 32'h0000_0500; ifc.mem_data_i = 32'h0;
        @(negedge clk);
        check("pre_reset_busy", ifc.bus_ce_o, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("async_reset", {ifc.bus_ce_o, ifc.bus_addr_o, ifc.mem_ack_o, ifc.if_ack_o, ifc.if_data_o, ifc.mem_data_o}, '0);
        exp_if_data = '0;
        exp_mem_data = '0;
        ifc.mem_req_i = 1'b0;
        ifc.if_req_i = 1'b1; ifc.if_addr_i = 32'h0000_0600;
        @(negedge clk);
        check("reset_hold", {ifc.bus_ce_o, ifc.mem_ack_o}, 2'b00);
        #2 rst = 1'b1;
        serve(1'b0, 32'h600, 1'b0, 4'hF, 32'h0, 32'h6060_6060, 0, 0, 0, 1'b0, 1'b0, 1'b1, 32'h6060_6060);
        exp_if_data = 32'h6060_6060;

`ifdef ARB_TIMEOUT_EN
        ifc.mem_req_i = 1'b1; ifc.mem_we_i = 1'b0; ifc.mem_sel_i = 4'hF;
        ifc.mem_addr_i = 32'h0000_0700; ifc.mem_data_i = 32'h0;
        @(negedge clk);
        cnt = 0;
        while (ifc.bus_ce_o && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_busy_cycles", cnt, 255);
        check("timeout_done", {ifc.mem_ack_o, ifc.bus_err_o}, 2'b00);
        ifc.mem_req_i = 1'b0;
        @(negedge clk);
        check("timeout_pulse", {ifc.mem_ack_o, ifc.if_ack_o, ifc.bus_err_o, ifc.mem_data_o}, {3'b101, 32'h0});
        @(negedge clk);
        check("timeout_after", {ifc.mem_ack_o, ifc.bus_err_o}, 2'b00);
        exp_mem_data = '0;
`endif

        for (int it = 0; it < 30; it++) begin
            pick    = $urandom_range(1, 3);
            m_we    = 1'($urandom());
            m_sel   = 4'($urandom());
            m_addr  = $urandom();
            m_wdata = $urandom();
            m_rdata = $urandom();
            m_wt    = $urandom_range(0, 4);
            m_drop  = $urandom_range(0, 1) ? $urandom_range(1, m_wt + 1) : 0;
            m_flush = $urandom_range(0, 1) ? $urandom_range(1, m_wt + 1) : 0;
            i_addr  = $urandom();
            i_rdata = $urandom();
            i_wt    = $urandom_range(0, 4);
            fl      = $urandom_range(0, 3);
            if (fl == 2) begin
                i_flush = $urandom_range(1, i_wt + 1);
                i_drop  = i_flush;
            end else if (fl == 3) begin
                i_flush = i_wt + 2;
                i_drop  = 0;
            end else begin
                i_flush = 0;
                i_drop  = $urandom_range(0, 1) ? $urandom_range(1, i_wt + 1) : 0;
            end
            if (pick[1]) begin
                ifc.mem_req_i = 1'b1; ifc.mem_we_i = m_we; ifc.mem_sel_i = m_sel;
                ifc.mem_addr_i = m_addr; ifc.mem_data_i = m_wdata;
            end
            if (pick[0]) begin
                ifc.if_req_i = 1'b1; ifc.if_addr_i = i_addr;
            end
            if (pick[1]) begin
                e_d = m_we ? exp_mem_data : m_rdata;
                serve(1'b1, m_addr, m_we, m_sel, m_wdata, m_rdata, m_wt, m_flush, m_drop,
                      1'($urandom()), 1'b0, 1'b1, e_d);
                exp_mem_data = e_d;
            end
            if (pick[0]) begin
                serve(1'b0, i_addr, 1'b0, 4'hF, 32'h0, i_rdata, i_wt, i_flush, i_drop,
                      1'($urandom()), 1'b0, (fl < 2), i_rdata);
                exp_if_data = i_rdata;
            end
            check("data_hold", {ifc.if_data_o, ifc.mem_data_o}, {exp_if_data, exp_mem_data});
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, all state on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports if_req_i (in, 1), if_addr_i (in, 32), if_data_o (out, 32), if_ack_o (out, 1): instruction-fetch read port.
REQ-004 SHALL have ports mem_req_i (in, 1), mem_we_i (in, 1), mem_sel_i (in, 4), mem_addr_i (in, 32), mem_data_i (in, 32), mem_data_o (out, 32), mem_ack_o (out, 1): load/store port.
REQ-005 SHALL have ports bus_ce_o (out, 1), bus_we_o (out, 1), bus_sel_o (out, 4), bus_addr_o (out, 32), bus_data_o (out, 32), bus_data_i (in, 32), bus_ack_i (in, 1): shared single-port memory bus.
REQ-006 SHALL have ports flush_i (in, 1): pipeline flush; stallreq_if_o (out, 1), stallreq_mem_o (out, 1): stall requests to pipeline control.
REQ-007 SHALL have port bus_err_o (out, 1), present only when ARB_TIMEOUT_EN is defined: timeout error pulse.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY_IF, BUSY_MEM, DONE.
REQ-009 IDLE: mem_req_i=1 -> BUSY_MEM; else if_req_i=1 -> BUSY_IF; else stay; MEM has fixed priority over IF.
REQ-010 On the IDLE->BUSY transition, the granted port's address/we/sel/data SHALL be registered onto bus_* outputs, with bus_ce_o=1 from the first BUSY cycle.
REQ-011 bus_* outputs SHALL remain constant for the whole BUSY state regardless of requester input changes.
REQ-012 IF grant: bus_we_o=0, bus_sel_o=4'hF, bus_data_o=0.
REQ-013 BUSY_x with bus_ack_i=1: bus_data_i SHALL be captured into x_data_o (loads only; stores leave mem_data_o unchanged), bus_ce_o SHALL be deasserted, and the FSM SHALL go to DONE.
REQ-014 DONE: exactly one-cycle pulse of the granted port's ack; unconditional return to IDLE; no arbitration in DONE.
REQ-015 Minimum latency: request sampled at edge N, bus_ce_o high after N, ack pulse after edge N+2 with a zero-wait bus_ack_i.
REQ-016 if_data_o and mem_data_o SHALL hold their last captured value until the next capture.
REQ-017 stallreq_if_o = if_req_i AND NOT if_ack_o, and stallreq_mem_o = mem_req_i AND NOT mem_ack_o, both combinational.
REQ-018 flush_i=1 during BUSY_IF or in IDLE/DONE with an IF grant pending: the bus transaction SHALL complete normally, and if_ack_o SHALL be suppressed for that transaction.
REQ-019 flush_i SHALL NOT affect a MEM transaction.
REQ-020 Requester dropping its req mid-transaction: the transaction SHALL complete and the ack SHALL still pulse.
REQ-021 bus_ack_i while in IDLE or DONE SHALL be ignored.

Reset
REQ-022 rst=0 SHALL immediately force state IDLE, and all outputs and registers to 0 (bus_ce_o=0, acks=0, data=0, bus_err_o=0), independent of clk.
REQ-023 Reset mid-transaction SHALL abandon the transaction with no ack; the first arbitration SHALL occur on the first clk edge after rst rises.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on BUSY entry and increment each BUSY cycle without bus_ack_i.
REQ-025 With ARB_TIMEOUT_EN, when the count reaches 255: bus_ce_o=0, go to DONE, pulse the ack with data 32'h0, and pulse bus_err_o for one cycle concurrent with the ack.
REQ-026 ARB_TIMEOUT_EN undefined: no counter and no bus_err_o port; BUSY SHALL wait indefinitely for bus_ack_i.

Verification
REQ-027 if_req_i=1, if_addr_i=32'h0000_0100, bus_ack_i in the first BUSY cycle with bus_data_i=32'h3421_0001 -> bus_addr_o=32'h100, bus_we_o=0, one if_ack_o pulse, if_data_o=32'h3421_0001.
REQ-028 if_req_i and mem_req_i asserted in the same cycle, mem store addr 32'h200, data 32'hDEAD_BEEF, sel 4'b0011 -> MEM served first (bus_we_o=1, bus_sel_o=4'b0011), then IF; stallreq_if_o=1 throughout until if_ack_o.
REQ-029 IF read with bus_ack_i delayed 5 cycles and flush_i pulsed on the 2nd BUSY cycle -> bus_ce_o high 6 cycles, no if_ack_o, FSM back in IDLE.
REQ-030 rst driven low between clk edges mid BUSY_MEM -> bus_ce_o=0 and state IDLE immediately; no mem_ack_o after rst rises.
REQ-031 ARB_TIMEOUT_EN defined, bus_ack_i held 0 -> after 255 BUSY cycles: mem_ack_o and bus_err_o pulse together, mem_data_o=0.
REQ-032 Back-to-back IF requests held high with zero-wait bus -> one if_ack_o every 3 cycles, with bus_addr_o tracking if_addr_i.
